// File: rtl/joybus_frame_controller_if.sv
// Signal bundle between the joybus frame controller, the serial decoder and the
// response transmitter. The controller uses the master modport.
interface joybus_frame_controller_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 6;

  logic              bit_strobe;
  logic              bit_value;
  logic              tx_done;
  logic              dec_enable;
  logic              dec_reset;
  logic [BYTE_W-1:0] rx_byte;
  logic              rx_byte_valid;
  logic [IDX_W-1:0]  rx_byte_index;
  logic [BYTE_W-1:0] cmd;
  logic              cmd_valid;
  logic              tx_start;
  logic [IDX_W-1:0]  tx_len;
  logic              frame_err;
  logic              busy;

  modport master (
    input  bit_strobe, bit_value, tx_done,
    output dec_enable, dec_reset, rx_byte, rx_byte_valid, rx_byte_index,
           cmd, cmd_valid, tx_start, tx_len, frame_err, busy
  );

  modport slave (
    output bit_strobe, bit_value, tx_done,
    input  dec_enable, dec_reset, rx_byte, rx_byte_valid, rx_byte_index,
           cmd, cmd_valid, tx_start, tx_len, frame_err, busy
  );
endinterface

// File: rtl/joybus_frame_controller.sv
// Joybus frame controller: gates the serial decoder, assembles request bytes,
// decodes the command length and hands the line to the response transmitter.
module joybus_frame_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned TURN_CYCLES    = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  joybus_frame_controller_if.master bus
);
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned TIMER_MAX = (TIMEOUT_CYCLES > TURN_CYCLES) ? TIMEOUT_CYCLES : TURN_CYCLES;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TURN_LAST    = TIMER_W'(TURN_CYCLES);

  typedef enum logic [2:0] {RECOVER, IDLE, RX, TURN, TX_WAIT} state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-2:0]   sr_q, sr_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [BYTE_W-1:0]   rx_byte_q, rx_byte_d;
  logic                rx_byte_valid_q, rx_byte_valid_d;
  logic [IDX_W-1:0]    rx_byte_index_q, rx_byte_index_d;
  logic [BYTE_W-1:0]   cmd_q, cmd_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                tx_start_q, tx_start_d;
  logic [IDX_W-1:0]    tx_len_q, tx_len_d;
  logic                frame_err_q, frame_err_d;
  logic                dec_enable_q, dec_enable_d;
  logic                dec_reset_q, dec_reset_d;
  logic                busy_q, busy_d;

  logic                accept;
  logic                byte_done;
  logic [BYTE_W-1:0]   new_byte;
  logic [BYTE_W-1:0]   cmd_src;
  logic [IDX_W-1:0]    last_idx;

  function automatic logic cmd_known(input logic [BYTE_W-1:0] c);
    return (c == 8'h00) || (c == 8'hFF) || (c == 8'h01) || (c == 8'h02) || (c == 8'h03);
  endfunction

  function automatic logic [IDX_W-1:0] cmd_rx_len(input logic [BYTE_W-1:0] c);
    case (c)
      8'h02:   return 6'd3;
      8'h03:   return 6'd35;
      default: return 6'd1;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] cmd_tx_len(input logic [BYTE_W-1:0] c);
    case (c)
      8'h01:   return 6'd4;
      8'h02:   return 6'd33;
      8'h03:   return 6'd1;
      default: return 6'd3;
    endcase
  endfunction

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d         = state_q;
    sr_d            = sr_q;
    bit_cnt_d       = bit_cnt_q;
    byte_cnt_d      = byte_cnt_q;
    timer_d         = timer_q;
    rx_byte_d       = rx_byte_q;
    rx_byte_valid_d = 1'b0;
    rx_byte_index_d = rx_byte_index_q;
    cmd_d           = cmd_q;
    cmd_valid_d     = 1'b0;
    tx_start_d      = 1'b0;
    tx_len_d        = tx_len_q;
    frame_err_d     = 1'b0;

    accept    = bus.bit_strobe && ((state_q == IDLE) || (state_q == RX));
    new_byte  = {sr_q, bus.bit_value};
    byte_done = accept && (bit_cnt_q == 3'd7);
    // The command byte's own length is decoded before it is latched
    cmd_src   = (byte_cnt_q == '0) ? new_byte : cmd_q;
    last_idx  = cmd_rx_len(cmd_src) - 6'd1;

    if (accept) begin
      sr_d      = new_byte[BYTE_W-2:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      timer_d   = '0;
      if (byte_done) begin
        rx_byte_d       = new_byte;
        rx_byte_valid_d = 1'b1;
        rx_byte_index_d = byte_cnt_q;
        byte_cnt_d      = byte_cnt_q + 6'd1;
        if (byte_cnt_q == '0) cmd_d = new_byte;
      end
    end

    case (state_q)
      RECOVER: begin
        state_d         = IDLE;
        sr_d            = '0;
        bit_cnt_d       = '0;
        byte_cnt_d      = '0;
        rx_byte_index_d = '0;
        timer_d         = '0;
      end
      IDLE: begin
        if (accept) state_d = RX;
      end
      RX: begin
        if (accept) begin
          if (byte_done && (byte_cnt_q == '0) && !cmd_known(new_byte)) begin
            frame_err_d = 1'b1;
            state_d     = RECOVER;
          end else if (byte_done && (byte_cnt_q == last_idx)) begin
            cmd_valid_d = 1'b1;
            state_d     = TURN;
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          frame_err_d = 1'b1;
          state_d     = RECOVER;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      TURN: begin
        if (timer_q == TURN_LAST) begin
          tx_start_d = 1'b1;
          tx_len_d   = cmd_tx_len(cmd_q);
          timer_d    = '0;
          state_d    = TX_WAIT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      TX_WAIT: begin
        if (bus.tx_done) begin
          state_d = RECOVER;
        end else if (timer_q == TIMEOUT_LAST) begin
          frame_err_d = 1'b1;
          state_d     = RECOVER;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = RECOVER;
    endcase

    dec_reset_d  = (state_d == RECOVER);
    dec_enable_d = (state_d == IDLE) || (state_d == RX);
    busy_d       = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= RECOVER;
      sr_q            <= '0;
      bit_cnt_q       <= '0;
      byte_cnt_q      <= '0;
      timer_q         <= '0;
      rx_byte_q       <= '0;
      rx_byte_valid_q <= 1'b0;
      rx_byte_index_q <= '0;
      cmd_q           <= '0;
      cmd_valid_q     <= 1'b0;
      tx_start_q      <= 1'b0;
      tx_len_q        <= '0;
      frame_err_q     <= 1'b0;
      dec_enable_q    <= 1'b0;
      dec_reset_q     <= 1'b1;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      sr_q            <= sr_d;
      bit_cnt_q       <= bit_cnt_d;
      byte_cnt_q      <= byte_cnt_d;
      timer_q         <= timer_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      rx_byte_index_q <= rx_byte_index_d;
      cmd_q           <= cmd_d;
      cmd_valid_q     <= cmd_valid_d;
      tx_start_q      <= tx_start_d;
      tx_len_q        <= tx_len_d;
      frame_err_q     <= frame_err_d;
      dec_enable_q    <= dec_enable_d;
      dec_reset_q     <= dec_reset_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.dec_enable    = dec_enable_q;
  assign bus.dec_reset     = dec_reset_q;
  assign bus.rx_byte       = rx_byte_q;
  assign bus.rx_byte_valid = rx_byte_valid_q;
  assign bus.rx_byte_index = rx_byte_index_q;
  assign bus.cmd           = cmd_q;
  assign bus.cmd_valid     = cmd_valid_q;
  assign bus.tx_start      = tx_start_q;
  assign bus.tx_len        = tx_len_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_joybus_frame_controller.sv
// Directed bench for the joybus frame controller.
module tb_joybus_frame_controller;
  localparam int unsigned TIMEOUT = 2000;
  localparam int unsigned TURN    = 64;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  joybus_frame_controller_if jif ();

  joybus_frame_controller #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .TURN_CYCLES   (TURN)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (jif.master)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    jif.bit_strobe = 1'b1;
    jif.bit_value  = v;
    tick();
    jif.bit_strobe = 1'b0;
    jif.bit_value  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b, input int idx);
    check({tag, "_valid"}, 32'(jif.rx_byte_valid), 1);
    check({tag, "_byte"},  32'(jif.rx_byte), 32'(b));
    check({tag, "_index"}, 32'(jif.rx_byte_index), 32'(idx));
  endtask

  // Ticks 'pre' cycles expecting no tx_start, then one more expecting it
  task automatic wait_tx_start(input string tag, input int pre, input int len);
    logic seen;
    seen = 1'b0;
    repeat (pre) begin
      tick();
      if (jif.tx_start) seen = 1'b1;
    end
    check({tag, "_early_tx_start"}, 32'(seen), 0);
    tick();
    check({tag, "_tx_start"}, 32'(jif.tx_start), 1);
    check({tag, "_tx_len"},   32'(jif.tx_len), 32'(len));
  endtask

  // Ticks 'n' cycles expecting no frame_err
  task automatic quiet_err(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      tick();
      if (jif.frame_err) seen = 1'b1;
    end
    check(tag, 32'(seen), 0);
  endtask

  initial begin
    logic seen_v;
    logic seen_c;
    n_checks       = 0;
    n_fail         = 0;
    jif.bit_strobe = 1'b0;
    jif.bit_value  = 1'b0;
    jif.tx_done    = 1'b0;
    reset_n        = 1'b1;
    #3 reset_n = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_dec_reset",  32'(jif.dec_reset), 1);
    check("rst_dec_enable", 32'(jif.dec_enable), 0);
    check("rst_busy",       32'(jif.busy), 0);
    check("rst_cmd_valid",  32'(jif.cmd_valid), 0);
    check("rst_tx_start",   32'(jif.tx_start), 0);
    check("rst_frame_err",  32'(jif.frame_err), 0);
    check("rst_index",      32'(jif.rx_byte_index), 0);
    check("rst_tx_len",     32'(jif.tx_len), 0);

    reset_n = 1'b1;
    tick();
    check("idle_dec_reset",  32'(jif.dec_reset), 0);
    check("idle_dec_enable", 32'(jif.dec_enable), 1);
    check("idle_busy",       32'(jif.busy), 0);

    // 1: info command, single byte request
    send_byte(8'h00);
    expect_byte("t1_b0", 8'h00, 0);
    check("t1_cmd",        32'(jif.cmd), 'h00);
    check("t1_cmd_valid",  32'(jif.cmd_valid), 1);
    check("t1_dec_enable", 32'(jif.dec_enable), 0);
    check("t1_busy",       32'(jif.busy), 1);
    tick();
    check("t1_valid_pulse", 32'(jif.rx_byte_valid), 0);
    check("t1_cmdv_pulse",  32'(jif.cmd_valid), 0);
    wait_tx_start("t1", 63, 3);
    tick();
    check("t1_tx_start_pulse", 32'(jif.tx_start), 0);
    check("t1_tx_len_hold",    32'(jif.tx_len), 3);
    jif.tx_done = 1'b1;
    tick();
    jif.tx_done = 1'b0;
    check("t1_rec_dec_reset", 32'(jif.dec_reset), 1);
    check("t1_rec_busy",      32'(jif.busy), 1);
    check("t1_rec_frame_err", 32'(jif.frame_err), 0);
    tick();
    check("t1_idle_dec_reset", 32'(jif.dec_reset), 0);
    check("t1_idle_busy",      32'(jif.busy), 0);

    // 2: read command with two address bytes, then TX timeout
    send_byte(8'h02);
    expect_byte("t2_b0", 8'h02, 0);
    check("t2_b0_no_cmdv", 32'(jif.cmd_valid), 0);
    send_byte(8'h80);
    expect_byte("t2_b1", 8'h80, 1);
    check("t2_b1_no_cmdv", 32'(jif.cmd_valid), 0);
    send_byte(8'h1F);
    expect_byte("t2_b2", 8'h1F, 2);
    check("t2_cmd_valid", 32'(jif.cmd_valid), 1);
    check("t2_cmd",       32'(jif.cmd), 'h02);
    wait_tx_start("t2", 64, 33);
    quiet_err("t2_tx_early_err", int'(TIMEOUT) - 1);
    tick();
    check("t2_tx_timeout_err", 32'(jif.frame_err), 1);
    check("t2_tx_timeout_rst", 32'(jif.dec_reset), 1);
    tick();
    check("t2_err_pulse", 32'(jif.frame_err), 0);
    check("t2_idle_busy", 32'(jif.busy), 0);

    // 3: write command with 34 data bytes; stray bits during turnaround
    send_byte(8'h03);
    expect_byte("t3_b0", 8'h03, 0);
    for (int i = 0; i < 34; i++) begin
      send_byte(8'(i));
      check("t3_data_valid", 32'(jif.rx_byte_valid), 1);
      check("t3_data_index", 32'(jif.rx_byte_index), 32'(i + 1));
    end
    check("t3_last_byte",  32'(jif.rx_byte), 'h21);
    check("t3_cmd_valid",  32'(jif.cmd_valid), 1);
    seen_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      if (jif.rx_byte_valid) seen_v = 1'b1;
    end
    check("t3_turn_no_byte",  32'(seen_v), 0);
    check("t3_turn_byte_hold", 32'(jif.rx_byte), 'h21);
    check("t3_turn_idx_hold",  32'(jif.rx_byte_index), 34);
    wait_tx_start("t3", 56, 1);
    jif.tx_done = 1'b1;
    tick();
    jif.tx_done = 1'b0;
    tick();
    check("t3_idle_busy", 32'(jif.busy), 0);

    // 4: unknown command aborts right after the command byte
    send_byte(8'h55);
    check("t4_valid",     32'(jif.rx_byte_valid), 1);
    check("t4_frame_err", 32'(jif.frame_err), 1);
    check("t4_dec_reset", 32'(jif.dec_reset), 1);
    check("t4_no_cmdv",   32'(jif.cmd_valid), 0);
    tick();
    check("t4_err_pulse", 32'(jif.frame_err), 0);
    check("t4_idle_busy", 32'(jif.busy), 0);
    seen_v = 1'b0;
    seen_c = 1'b0;
    repeat (70) begin
      tick();
      if (jif.tx_start) seen_v = 1'b1;
      if (jif.cmd_valid) seen_c = 1'b1;
    end
    check("t4_no_tx_start", 32'(seen_v), 0);
    check("t4_no_cmd_valid", 32'(seen_c), 0);

    // 5a: truncated read request times out
    send_byte(8'h02);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    quiet_err("t5_early_err", int'(TIMEOUT) - 1);
    tick();
    check("t5_timeout_err", 32'(jif.frame_err), 1);
    check("t5_timeout_rst", 32'(jif.dec_reset), 1);
    tick();
    check("t5_idle_busy", 32'(jif.busy), 0);

    // 5b: strobe on the expiry cycle wins; frame continues to completion
    send_byte(8'h02);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    quiet_err("t5b_early_err", int'(TIMEOUT) - 1);
    send_bit(1'b1);
    check("t5b_no_err",    32'(jif.frame_err), 0);
    check("t5b_busy",      32'(jif.busy), 1);
    check("t5b_dec_en",    32'(jif.dec_enable), 1);
    send_bit(1'b0);
    send_bit(1'b1);
    expect_byte("t5b_b1", 8'hA5, 1);
    send_byte(8'h00);
    expect_byte("t5b_b2", 8'h00, 2);
    check("t5b_cmd_valid", 32'(jif.cmd_valid), 1);
    wait_tx_start("t5b", 64, 33);

    // 6: reset during TX_WAIT aborts silently
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("t6_dec_reset", 32'(jif.dec_reset), 1);
    check("t6_busy",      32'(jif.busy), 0);
    check("t6_frame_err", 32'(jif.frame_err), 0);
    check("t6_tx_start",  32'(jif.tx_start), 0);
    check("t6_tx_len",    32'(jif.tx_len), 0);
    tick();
    reset_n = 1'b1;
    tick();
    jif.tx_done = 1'b1;
    tick();
    jif.tx_done = 1'b0;
    check("t6_done_ignored_rst",  32'(jif.dec_reset), 0);
    check("t6_done_ignored_busy", 32'(jif.busy), 0);
    check("t6_done_ignored_err",  32'(jif.frame_err), 0);
    tick();
    check("t6_still_idle", 32'(jif.dec_enable), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
